// File: rtl/audio_pwm_pkg.sv
// Shared audio/PWM types for the generator and decoder.
package audio_pwm_pkg;
  localparam int AUDIO_W    = 12;
  localparam int PWM_PERIOD = 1 << AUDIO_W;

  typedef logic [AUDIO_W-1:0] audio_t;

  typedef enum logic {IDLE, MEASURE} pwm_dec_state_t;
endpackage

// File: rtl/pwm_input_sync.sv
// Flop-chain synchronizer for an asynchronous single-bit input.
module pwm_input_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic d_i,
  output logic s_o
);
  logic [SYNC_STAGES-1:0] sync_q;

  always_ff @(posedge clk) begin
    if (rst) sync_q <= '0;
    else     sync_q <= {sync_q[SYNC_STAGES-2:0], d_i};
  end

  assign s_o = sync_q[SYNC_STAGES-1];
endmodule

// File: rtl/audio_pwm_decoder.sv
// PWM-to-sample decoder: counts high cycles per frame between rising edges.
// Optional AUDIO_PWM_DECODER_FILTER_EN averages each sample with the previous one.
module audio_pwm_decoder
  import audio_pwm_pkg::*;
#(
  parameter int WIDTH       = AUDIO_W,
  parameter int PERIOD      = PWM_PERIOD,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ena,
  input  logic             pwm_in,
  output logic [WIDTH-1:0] audio,
  output logic             audio_valid,
  output logic             frame_err
);
  localparam int CW = WIDTH + 1;
  localparam logic [CW-1:0] PER  = CW'(PERIOD);
  localparam logic [CW-1:0] MAXV = {1'b0, {WIDTH{1'b1}}};

  pwm_dec_state_t   state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d, hi_q, hi_d;
  logic [WIDTH-1:0] audio_q, audio_d, raw, filt;
  logic             valid_q, valid_d, err_q, err_d;
  logic             s, s_prev_q, rise, frame_end, pub, idle_exit;

  pwm_input_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
    .clk (clk),
    .rst (rst),
    .d_i (pwm_in),
    .s_o (s)
  );

  assign rise      = s & ~s_prev_q;
  assign frame_end = rise | (cnt_q == PER);
  assign pub       = ena & frame_end & (state_q == MEASURE);
  assign idle_exit = ena & frame_end & (state_q == IDLE);
  // Constant-high input times out with hi == PERIOD, which does not fit WIDTH bits.
  assign raw       = (hi_q > MAXV) ? MAXV[WIDTH-1:0] : hi_q[WIDTH-1:0];

`ifdef AUDIO_PWM_DECODER_FILTER_EN
  logic [WIDTH-1:0] r_prev_q;
  logic             r_vld_q;
  logic [CW-1:0]    sum;

  assign sum  = CW'(raw) + CW'(r_prev_q) + CW'(1);
  assign filt = r_vld_q ? sum[CW-1:1] : raw;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_prev_q <= '0;
      r_vld_q  <= 1'b0;
    end else if (idle_exit) begin
      r_prev_q <= '0;
      r_vld_q  <= 1'b0;
    end else if (pub) begin
      r_prev_q <= raw;
      r_vld_q  <= 1'b1;
    end
  end
`else
  assign filt = raw;
`endif

  always_ff @(posedge clk) begin
    if (rst)      state_q <= IDLE;
    else if (ena) state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (state_q == IDLE && frame_end) state_d = MEASURE;
  end

  always_comb begin
    cnt_d = cnt_q;
    hi_d  = hi_q;
    if (ena) begin
      if (rise) begin
        cnt_d = CW'(1);
        hi_d  = CW'(1);
      end else if (cnt_q == PER) begin
        cnt_d = CW'(1);
        hi_d  = CW'(s);
      end else begin
        cnt_d = cnt_q + CW'(1);
        hi_d  = hi_q + CW'(s);
      end
    end
  end

  always_comb begin
    valid_d = pub;
    audio_d = audio_q;
    err_d   = err_q;
    if (pub) begin
      audio_d = filt;
      err_d   = (cnt_q != PER);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s_prev_q <= 1'b0;
      cnt_q    <= '0;
      hi_q     <= '0;
      audio_q  <= '0;
      valid_q  <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      valid_q <= valid_d;
      if (ena) begin
        s_prev_q <= s;
        cnt_q    <= cnt_d;
        hi_q     <= hi_d;
        audio_q  <= audio_d;
        err_q    <= err_d;
      end
    end
  end

  assign audio       = audio_q;
  assign audio_valid = valid_q;
  assign frame_err   = err_q;
endmodule

// File: tb/tb_audio_pwm_decoder.sv
// Directed bench for audio_pwm_decoder: framed PWM stimulus with a publish scoreboard.
module tb_audio_pwm_decoder;
  localparam int PERIOD = 4096;

  typedef struct {
    logic [31:0] a;
    logic        e;
    int          t;
  } exp_t;

  logic        clk, rst, ena, pwm_in;
  logic [11:0] audio;
  logic        audio_valid, frame_err;

  int   cyc = 0;
  int   nvec = 0;
  int   nerr = 0;
  exp_t sb[$];
  int   pend_a;
  logic pend_e;
  bit   pend_v;
`ifdef AUDIO_PWM_DECODER_FILTER_EN
  int   f_prev;
  bit   f_first;
`endif

  audio_pwm_decoder dut (
    .clk         (clk),
    .rst         (rst),
    .ena         (ena),
    .pwm_in      (pwm_in),
    .audio       (audio),
    .audio_valid (audio_valid),
    .frame_err   (frame_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    nvec++;
    assert (obs === expv) else begin
      nerr++;
      $error("FAIL %s: observed %0d expected %0d (cycle %0d)", tag, obs, expv, cyc);
    end
  endtask

  // Queue the expected publish of the frame that just ended.
  task automatic push_pend(input int t);
    exp_t e;
`ifdef AUDIO_PWM_DECODER_FILTER_EN
    e.a = f_first ? pend_a : (pend_a + f_prev + 1) >> 1;
    f_prev  = pend_a;
    f_first = 0;
`else
    e.a = pend_a;
`endif
    e.e = pend_e;
    e.t = t;
    sb.push_back(e);
  endtask

  // Advance to the next falling edge and score any publish seen there.
  task automatic tick();
    exp_t e;
    @(negedge clk);
    if (audio_valid === 1'b1) begin
      if (sb.size() == 0) chk("spurious_valid", 32'(audio_valid), 32'd0);
      else begin
        e = sb.pop_front();
        chk("audio", 32'(audio), e.a);
        chk("frame_err", 32'(frame_err), 32'(e.e));
        chk("valid_cycle", cyc, e.t);
      end
    end
  endtask

  // One frame: rising edge at its first cycle (when hi>0), hi cycles high, len total.
  task automatic frame(input int hi, input int len);
    for (int i = 0; i < len; i++) begin
      tick();
      if (i == 0) begin
        if (pend_v) push_pend(cyc + 3);
        pend_a = (hi >= PERIOD) ? PERIOD - 1 : hi;
        pend_e = (len != PERIOD);
        pend_v = 1;
      end
      pwm_in = (i < hi);
    end
  endtask

  initial begin
    rst = 1'b1; ena = 1'b1; pwm_in = 1'b0; pend_v = 0;
`ifdef AUDIO_PWM_DECODER_FILTER_EN
    f_first = 1; f_prev = 0;
`endif
    repeat (3) tick();
    chk("rst_audio", 32'(audio), 32'd0);
    chk("rst_valid", 32'(audio_valid), 32'd0);
    chk("rst_err", 32'(frame_err), 32'd0);
    rst = 1'b0;

    frame(12'h800, PERIOD);
    frame(12'h800, PERIOD);
    frame(12'h100, PERIOD);
    frame(12'h101, PERIOD);
    frame(12'h102, PERIOD);
    frame(12'hFFF, PERIOD);
    frame(1000, 3000);
    frame(500, PERIOD);
    frame(0, PERIOD);
    frame(0, PERIOD);
    frame(1234, PERIOD);

    // Reset in the low phase of a frame; the 1234 publish lands just before it.
    for (int i = 0; i < PERIOD; i++) begin
      tick();
      if (i == 0) begin
        push_pend(cyc + 3);
        pend_v = 0;
      end
      if (i == 200) rst = 1'b1;
      if (i == 201) begin
        chk("midrst_audio", 32'(audio), 32'd0);
        chk("midrst_valid", 32'(audio_valid), 32'd0);
        chk("midrst_err", 32'(frame_err), 32'd0);
        rst = 1'b0;
      end
      pwm_in = (i < 100);
    end
`ifdef AUDIO_PWM_DECODER_FILTER_EN
    f_first = 1;
`endif

    frame(100, PERIOD);
    frame(200, PERIOD);

    // 500 disabled cycles inside the high phase: 800 enabled high, 4096 enabled total.
    for (int i = 0; i < PERIOD + 500; i++) begin
      tick();
      if (i == 0) begin
        push_pend(cyc + 3);
        pend_a = 800;
        pend_e = 1'b0;
        pend_v = 1;
      end
      ena    = !(i >= 400 && i < 900);
      pwm_in = (i < 1300);
    end
    ena = 1'b1;

    frame(300, 20);
    repeat (10) tick();
    chk("sb_drained", sb.size(), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
